multi_edge_detector: RTL

//  Multi-channel successor to the single-bit HCLK edge detector. Each channel

---
 rtl/multi_edge_detector.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel async-input edge detector: synchroniser, stability filter, registered rise/fall pulses, sticky flags.
// Optional per-channel saturating edge counter enabled by defining MULTI_EDGE_DETECTOR_CNT_EN.
module multi_edge_detector #(
  parameter int   CHANNELS      = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   rise_pulse,
  output logic [CHANNELS-1:0]   fall_pulse,
  output logic [CHANNELS-1:0]   rise_flag,
  output logic [CHANNELS-1:0]   fall_flag,
  output logic [CHANNELS-1:0]   overrun
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  ,
  output logic [8*CHANNELS-1:0] edge_count
`endif
);

  localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(FILTER_CYCLES);
  localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_LEVEL}};

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0] synced;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] rise_ev, fall_ev;
  logic [CHANNELS-1:0] rise_pulse_q, rise_pulse_d;
  logic [CHANNELS-1:0] fall_pulse_q, fall_pulse_d;
  logic [CHANNELS-1:0] rise_flag_q, rise_flag_d;
  logic [CHANNELS-1:0] fall_flag_q, fall_flag_d;
  logic [CHANNELS-1:0] overrun_q, overrun_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // A level change is accepted only after FILTER_CYCLES+1 consecutive mismatching cycles.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (synced[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = synced[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise_ev      = level_q & ~prev_q;
    fall_ev      = ~level_q & prev_q;
    prev_d       = level_q;
    rise_pulse_d = rise_ev;
    fall_pulse_d = fall_ev;
    // A same-cycle event beats clear for the flag, but never raises overrun.
    rise_flag_d  = rise_ev | (rise_flag_q & ~clear);
    fall_flag_d  = fall_ev | (fall_flag_q & ~clear);
    overrun_d    = ~clear & (overrun_q | (rise_ev & rise_flag_q) | (fall_ev & fall_flag_q));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q       <= {SYNC_STAGES{RST_VEC}};
      cnt_q        <= '0;
      level_q      <= RST_VEC;
      prev_q       <= RST_VEC;
      rise_pulse_q <= '0;
      fall_pulse_q <= '0;
      rise_flag_q  <= '0;
      fall_flag_q  <= '0;
      overrun_q    <= '0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      prev_q       <= prev_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      rise_flag_q  <= rise_flag_d;
      fall_flag_q  <= fall_flag_d;
      overrun_q    <= overrun_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign rise_flag  = rise_flag_q;
  assign fall_flag  = fall_flag_q;
  assign overrun    = overrun_q;

`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  logic [CHANNELS-1:0][7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        ecnt_d[i] = {7'd0, rise_ev[i] | fall_ev[i]};
      end else if ((rise_ev[i] | fall_ev[i]) && (ecnt_q[i] != 8'hFF)) begin
        ecnt_d[i] = ecnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign edge_count = ecnt_q;
`else
  // Counter build option disabled: no edge_count port or counter state.
`endif

endmodule
